// File: rtl/udm_bridge_pkg.sv
// Shared constants and types for the UDM command bridge: register window layout,
// STATUS bit map and the per-channel command FSM state type.
package udm_bridge_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned WIN_SIZE     = 32'h40;
    localparam int unsigned WIN_AW       = $clog2(WIN_SIZE);

    localparam logic [WIN_AW-1:0] OFF_CTRL     = 6'h00;
    localparam logic [WIN_AW-1:0] OFF_ARG0     = 6'h04;
    localparam logic [WIN_AW-1:0] OFF_RESP_POP = 6'h30;
    localparam logic [WIN_AW-1:0] OFF_CLR      = 6'h34;

    localparam int unsigned ST_BUSY       = 0;
    localparam int unsigned ST_RESP_VALID = 1;
    localparam int unsigned ST_OVERFLOW   = 2;
    localparam int unsigned ST_REJECT     = 3;
    localparam int unsigned ST_COUNT_LSB  = 8;
    localparam int unsigned ST_COUNT_W    = 8;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_e;

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [3:0]        be;
        logic [WORD_W-1:0] wdata;
    } bus_req_t;

    // Window offset of argument word k.
    function automatic logic [WIN_AW-1:0] arg_offset(input int k);
        return WIN_AW'(32'(OFF_ARG0) + 32'd4 * 32'(k));
    endfunction

    // Assemble a STATUS word from its fields.
    function automatic logic [WORD_W-1:0] pack_status(
        input logic                  busy,
        input logic                  valid,
        input logic                  ovf,
        input logic                  rej,
        input logic [ST_COUNT_W-1:0] cnt
    );
        logic [WORD_W-1:0] s;
        s                                = '0;
        s[ST_BUSY]                       = busy;
        s[ST_RESP_VALID]                 = valid;
        s[ST_OVERFLOW]                   = ovf;
        s[ST_REJECT]                     = rej;
        s[ST_COUNT_LSB +: ST_COUNT_W]    = cnt;
        return s;
    endfunction

endpackage

// File: rtl/udm_bridge_fifo.sv
// Per-channel response FIFO: power-of-2 depth, wrapping pointers, occupancy count.
module udm_bridge_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/udm_cmd_bridge.sv
// Bus-to-command bridge: per-channel argument staging, launch/hold command FSM,
// and a response FIFO drained through a RESP_POP register read.
module udm_cmd_bridge
    import udm_bridge_pkg::*;
#(
    parameter int unsigned CH_NUM     = 2,
    parameter int unsigned ARG_NUM    = 4,
    parameter int unsigned RESP_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic                          bus_req_i,
    input  logic                          bus_we_i,
    input  logic [31:0]                   bus_addr_bi,
    input  logic [3:0]                    bus_be_bi,
    input  logic [31:0]                   bus_wdata_bi,
    output logic                          bus_ack_o,
    output logic                          bus_resp_o,
    output logic [31:0]                   bus_rdata_bo,
    output logic [CH_NUM-1:0]             cmd_req_o,
    output logic [CH_NUM*ARG_NUM*32-1:0]  cmd_data_bo,
    input  logic [CH_NUM-1:0]             cmd_ack_i,
    input  logic [CH_NUM-1:0]             resp_req_i,
    input  logic [CH_NUM*32-1:0]          resp_data_bi,
    output logic [CH_NUM-1:0]             resp_ack_o
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;

    bus_req_t             bus;
    logic [31:0]          win_off;
    logic [WIN_AW-1:0]    reg_off;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [CH_NUM-1:0]    ch_sel;
    logic [ARG_NUM-1:0]   arg_hit;
    logic [CH_NUM-1:0]    launch;
    logic [CH_NUM-1:0]    clr_wr;
    logic [CH_NUM-1:0]    rd_pop;
    logic [CH_NUM-1:0]    ovf_set;
    logic [CH_NUM-1:0]    rej_set;
    logic [31:0]          rd_mux;

    ch_state_e            state_q  [CH_NUM];
    logic [31:0]          stage_q  [CH_NUM][ARG_NUM];
    logic [31:0]          cmd_q    [CH_NUM][ARG_NUM];
    logic [CH_NUM-1:0]    ovf_q;
    logic [CH_NUM-1:0]    rej_q;
    logic                 resp_q;
    logic [31:0]          rdata_q;

    logic [31:0]          fifo_head  [CH_NUM];
    logic [CNT_W-1:0]     fifo_count [CH_NUM];
    logic [31:0]          status     [CH_NUM];
    logic [CH_NUM-1:0]    fifo_full;
    logic [CH_NUM-1:0]    fifo_empty;

    assign bus = '{we: bus_we_i, addr: bus_addr_bi, be: bus_be_bi, wdata: bus_wdata_bi};

    // Every request is taken in the cycle it is presented.
    assign bus_ack_o = bus_req_i;
    assign win_off   = bus.addr - BASE_ADDR;
    assign reg_off   = win_off[WIN_AW-1:0];
    assign wr_ok     = bus_req_i && bus.we && (bus.be == 4'hF);
    assign rd_ok     = bus_req_i && !bus.we;

    // Address decode into per-channel strobes.
    always_comb begin
        ch_sel  = '0;
        arg_hit = '0;
        launch  = '0;
        clr_wr  = '0;
        rd_pop  = '0;
        ovf_set = '0;
        rej_set = '0;
        for (int k = 0; k < ARG_NUM; k++) begin
            arg_hit[k] = (reg_off == arg_offset(k));
        end
        for (int c = 0; c < CH_NUM; c++) begin
            ch_sel[c]  = (win_off[31:WIN_AW] == (32-WIN_AW)'(c));
            launch[c]  = wr_ok && ch_sel[c] && (reg_off == OFF_CTRL) && bus.wdata[0];
            clr_wr[c]  = wr_ok && ch_sel[c] && (reg_off == OFF_CLR);
            rd_pop[c]  = rd_ok && ch_sel[c] && (reg_off == OFF_RESP_POP);
            ovf_set[c] = resp_req_i[c] && fifo_full[c];
            rej_set[c] = launch[c] && (state_q[c] == CH_PEND);
        end
    end

    // Read data mux, sampled at acceptance; RESP_POP sees the pre-pop head.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (ch_sel[c]) begin
                if (reg_off == OFF_CTRL) begin
                    rd_mux = status[c];
                end else if (reg_off == OFF_RESP_POP) begin
                    rd_mux = fifo_empty[c] ? '0 : fifo_head[c];
                end
                for (int k = 0; k < ARG_NUM; k++) begin
                    if (arg_hit[k]) rd_mux = stage_q[c][k];
                end
            end
        end
    end

    // Per-channel staging, command FSM and sticky flags.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ovf_q <= '0;
            rej_q <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                state_q[c] <= CH_IDLE;
                for (int k = 0; k < ARG_NUM; k++) begin
                    stage_q[c][k] <= '0;
                    cmd_q[c][k]   <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int k = 0; k < ARG_NUM; k++) begin
                    if (wr_ok && ch_sel[c] && arg_hit[k]) stage_q[c][k] <= bus.wdata;
                end
                case (state_q[c])
                    CH_IDLE: begin
                        if (launch[c]) begin
                            state_q[c] <= CH_PEND;
                            for (int k = 0; k < ARG_NUM; k++) begin
                                cmd_q[c][k] <= stage_q[c][k];
                            end
                        end
                    end
                    CH_PEND: begin
                        if (cmd_ack_i[c]) state_q[c] <= CH_IDLE;
                    end
                endcase
                // A set event in the same cycle as a clear wins.
                ovf_q[c] <= ovf_set[c] || (ovf_q[c] && !(clr_wr[c] && bus.wdata[0]));
                rej_q[c] <= rej_set[c] || (rej_q[c] && !(clr_wr[c] && bus.wdata[1]));
            end
        end
    end

    // Bus response: one cycle after acceptance, data forced to 0 otherwise.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= rd_ok;
            rdata_q <= rd_ok ? rd_mux : '0;
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        udm_bridge_fifo #(
            .WIDTH (32),
            .DEPTH (RESP_DEPTH)
        ) u_fifo (
            .clk   (clk_i),
            .rst_n (arst_n_i),
            .push  (resp_req_i[c]),
            .wdata (resp_data_bi[c*32 +: 32]),
            .pop   (rd_pop[c]),
            .rdata (fifo_head[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c]),
            .count (fifo_count[c])
        );

        assign resp_ack_o[c] = !fifo_full[c];
        assign cmd_req_o[c]  = (state_q[c] == CH_PEND);
        assign status[c]     = pack_status(state_q[c] == CH_PEND, !fifo_empty[c],
                                           ovf_q[c], rej_q[c], ST_COUNT_W'(fifo_count[c]));

        for (genvar k = 0; k < ARG_NUM; k++) begin : g_arg
            assign cmd_data_bo[(c*ARG_NUM+k)*32 +: 32] = cmd_q[c][k];
        end
    end

endmodule

// File: tb/tb_udm_cmd_bridge.sv
// Self-checking bench for udm_cmd_bridge: randomized traffic against a queue-based
// reference model, followed by directed launch/reject/FIFO/bus-edge/reset scenarios.
module tb_udm_cmd_bridge;

    localparam int unsigned CH   = 2;
    localparam int unsigned AN   = 4;
    localparam int unsigned DEP  = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic                  clk_i        = 1'b0;
    logic                  arst_n_i     = 1'b0;
    logic                  bus_req_i    = 1'b0;
    logic                  bus_we_i     = 1'b0;
    logic [31:0]           bus_addr_bi  = '0;
    logic [3:0]            bus_be_bi    = '0;
    logic [31:0]           bus_wdata_bi = '0;
    logic                  bus_ack_o;
    logic                  bus_resp_o;
    logic [31:0]           bus_rdata_bo;
    logic [CH-1:0]         cmd_req_o;
    logic [CH*AN*32-1:0]   cmd_data_bo;
    logic [CH-1:0]         cmd_ack_i    = '0;
    logic [CH-1:0]         resp_req_i   = '0;
    logic [CH*32-1:0]      resp_data_bi = '0;
    logic [CH-1:0]         resp_ack_o;

    always #5 clk_i = ~clk_i;

    udm_cmd_bridge #(
        .CH_NUM     (CH),
        .ARG_NUM    (AN),
        .RESP_DEPTH (DEP),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_addr_bi  (bus_addr_bi),
        .bus_be_bi    (bus_be_bi),
        .bus_wdata_bi (bus_wdata_bi),
        .bus_ack_o    (bus_ack_o),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .cmd_req_o    (cmd_req_o),
        .cmd_data_bo  (cmd_data_bo),
        .cmd_ack_i    (cmd_ack_i),
        .resp_req_i   (resp_req_i),
        .resp_data_bi (resp_data_bi),
        .resp_ack_o   (resp_ack_o)
    );

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain queues and arrays.
    logic [31:0] m_fifo  [CH][$];
    logic [31:0] m_stage [CH][AN];
    logic [31:0] m_cmd   [CH][AN];
    bit          m_pend  [CH];
    bit          m_ovf   [CH];
    bit          m_rej   [CH];

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_fifo[c].delete();
            m_pend[c] = 1'b0;
            m_ovf[c]  = 1'b0;
            m_rej[c]  = 1'b0;
            for (int k = 0; k < AN; k++) begin
                m_stage[c][k] = '0;
                m_cmd[c][k]   = '0;
            end
        end
    endfunction

    function automatic logic [31:0] m_status(input int c);
        int n;
        n = m_fifo[c].size();
        return 32'(n) * 32'h100 + (m_rej[c] ? 32'd8 : 32'd0) + (m_ovf[c] ? 32'd4 : 32'd0)
             + ((n != 0) ? 32'd2 : 32'd0) + (m_pend[c] ? 32'd1 : 32'd0);
    endfunction

    function automatic logic [31:0] addr_of(input int c, input int off);
        return BASE + 32'(c * 64 + off);
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        bus_req_i    = 1'b1;
        bus_we_i     = 1'b1;
        bus_addr_bi  = addr;
        bus_be_bi    = be;
        bus_wdata_bi = wdata;
        @(posedge clk_i); #1;
        bus_req_i    = 1'b0;
        bus_we_i     = 1'b0;
        bus_be_bi    = '0;
        bus_wdata_bi = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b0;
        bus_addr_bi = addr;
        bus_be_bi   = 4'hF;
        #1 chk("rd_ack", 32'(bus_ack_o), 32'd1);
        @(posedge clk_i); #1;
        bus_req_i = 1'b0;
        chk("rd_resp", 32'(bus_resp_o), 32'd1);
        data = bus_rdata_bo;
        @(posedge clk_i); #1;
        chk("rd_resp_drop", 32'(bus_resp_o), 32'd0);
        chk("rd_idle_data", bus_rdata_bo, 32'd0);
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        #1;
        chk("rst_bus_resp", 32'(bus_resp_o), 32'd0);
        chk("rst_rdata", bus_rdata_bo, 32'd0);
        chk("rst_cmd_req", 32'(cmd_req_o), 32'd0);
        chk("rst_cmd_data", (|cmd_data_bo) ? 32'd1 : 32'd0, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        model_reset();
        chk("rst_resp_ack", 32'(resp_ack_o), 32'(2**CH - 1));
    endtask

    // Random-phase scratch state
    int          op, rc, rk, kind, hs;
    bit          is_rd, is_wr, full_b, ovf_s, launch, clr;
    logic [31:0] wd, exp_rd, rv;
    logic [3:0]  be;
    bit          exp_resp;

    localparam int K_NONE = 0, K_ARG = 1, K_CTRL = 2, K_CLR = 3, K_POP = 4, K_UNM = 5;

    initial begin
        model_reset();
        do_reset();

        // Randomized traffic against the reference model
        exp_resp = 1'b0;
        exp_rd   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rand_bus_resp", 32'(bus_resp_o), 32'(exp_resp));
            chk("rand_rdata", bus_rdata_bo, exp_rd);
            for (int c = 0; c < CH; c++) begin
                chk("rand_cmd_req", 32'(cmd_req_o[c]), 32'(m_pend[c]));
                chk("rand_resp_ack", 32'(resp_ack_o[c]), 32'(m_fifo[c].size() < DEP));
                if (m_pend[c]) begin
                    for (int k = 0; k < AN; k++)
                        chk("rand_cmd_data", cmd_data_bo[(c*AN+k)*32 +: 32], m_cmd[c][k]);
                end
            end

            op    = int'($urandom_range(0, 9));
            rc    = int'($urandom_range(0, CH - 1));
            rk    = int'($urandom_range(0, AN));
            wd    = $urandom;
            be    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            is_rd = 1'b0;
            is_wr = 1'b0;
            kind  = K_NONE;
            case (op)
                2: begin kind = K_ARG;  is_wr = 1'b1; bus_addr_bi = addr_of(rc, 4 + 4*rk); end
                3: begin kind = K_CTRL; is_wr = 1'b1; bus_addr_bi = addr_of(rc, 'h00);
                         wd[0] = ($urandom_range(0, 3) != 0); end
                4: begin kind = K_CLR;  is_wr = 1'b1; bus_addr_bi = addr_of(rc, 'h34); end
                5: begin kind = K_CTRL; is_rd = 1'b1; bus_addr_bi = addr_of(rc, 'h00); end
                6: begin kind = K_ARG;  is_rd = 1'b1; bus_addr_bi = addr_of(rc, 4 + 4*rk); end
                7, 8: begin kind = K_POP; is_rd = 1'b1; bus_addr_bi = addr_of(rc, 'h30); end
                9: begin
                    kind = K_UNM;
                    is_wr = ($urandom_range(0, 1) == 1);
                    is_rd = !is_wr;
                    bus_addr_bi = ($urandom_range(0, 1) == 1) ? addr_of(CH, 4 * int'($urandom_range(0, 15)))
                                                              : addr_of(rc, 'h38);
                end
                default: kind = K_NONE;
            endcase
            bus_req_i    = is_rd || is_wr;
            bus_we_i     = is_wr;
            bus_be_bi    = be;
            bus_wdata_bi = wd;
            for (int c = 0; c < CH; c++) begin
                resp_req_i[c]             = ($urandom_range(0, 9) < 4);
                resp_data_bi[c*32 +: 32]  = $urandom;
                cmd_ack_i[c]              = ($urandom_range(0, 9) < 3);
            end

            // Expected read value from the pre-edge model state
            rv = '0;
            if (is_rd) begin
                case (kind)
                    K_CTRL:  rv = m_status(rc);
                    K_ARG:   rv = (rk < AN) ? m_stage[rc][rk] : 32'd0;
                    K_POP:   rv = (m_fifo[rc].size() != 0) ? m_fifo[rc][0] : 32'd0;
                    default: rv = '0;
                endcase
            end
            #1 chk("rand_bus_ack", 32'(bus_ack_o), 32'(bus_req_i));

            @(posedge clk_i); #1;

            for (int c = 0; c < CH; c++) begin
                full_b = (m_fifo[c].size() >= DEP);
                ovf_s  = 1'b0;
                if (is_rd && kind == K_POP && rc == c && m_fifo[c].size() != 0)
                    void'(m_fifo[c].pop_front());
                if (resp_req_i[c]) begin
                    if (full_b) ovf_s = 1'b1;
                    else m_fifo[c].push_back(resp_data_bi[c*32 +: 32]);
                end
                launch = is_wr && be == 4'hF && kind == K_CTRL && rc == c && wd[0];
                clr    = is_wr && be == 4'hF && kind == K_CLR && rc == c;
                if (m_pend[c]) begin
                    if (launch) m_rej[c] = 1'b1;
                    if (cmd_ack_i[c]) m_pend[c] = 1'b0;
                end else if (launch) begin
                    m_pend[c] = 1'b1;
                    for (int k = 0; k < AN; k++) m_cmd[c][k] = m_stage[c][k];
                end
                if (clr) begin
                    if (wd[0]) m_ovf[c] = 1'b0;
                    if (wd[1] && !(launch && m_rej[c])) m_rej[c] = 1'b0;
                end
                if (ovf_s) m_ovf[c] = 1'b1;
                if (is_wr && be == 4'hF && kind == K_ARG && rc == c && rk < AN)
                    m_stage[c][rk] = wd;
            end
            exp_resp = is_rd;
            exp_rd   = rv;
        end
        bus_req_i  = 1'b0;
        bus_we_i   = 1'b0;
        resp_req_i = '0;
        cmd_ack_i  = '0;
        @(posedge clk_i); #1;
        do_reset();

        // Launch and hold with ack withheld
        bus_write(addr_of(0, 'h04), 32'hA5A5_0001, 4'hF);
        bus_write(addr_of(0, 'h08), 32'h0000_0002, 4'hF);
        bus_write(addr_of(0, 'h00), 32'h0000_0001, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 32'(cmd_req_o[0]), 32'd1);
            chk("hold_arg0", cmd_data_bo[31:0], 32'hA5A5_0001);
            chk("hold_arg1", cmd_data_bo[63:32], 32'h0000_0002);
            @(posedge clk_i); #1;
        end
        cmd_ack_i[0] = 1'b1;
        @(posedge clk_i); #1;
        cmd_ack_i[0] = 1'b0;
        chk("hold_drop", 32'(cmd_req_o[0]), 32'd0);

        // Second launch while pending is rejected
        bus_write(addr_of(1, 'h00), 32'h1, 4'hF);
        bus_write(addr_of(1, 'h00), 32'h1, 4'hF);
        bus_read(addr_of(1, 'h00), rv);
        chk("reject_status", rv, 32'h0000_0009);
        hs = 0;
        cmd_ack_i[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cmd_req_o[1] && cmd_ack_i[1]) hs++;
            @(posedge clk_i); #1;
        end
        cmd_ack_i[1] = 1'b0;
        chk("reject_handshakes", 32'(hs), 32'd1);
        bus_read(addr_of(1, 'h00), rv);
        chk("reject_sticky", rv, 32'h0000_0008);

        // Fill ch0 past capacity
        for (int i = 1; i <= 9; i++) begin
            resp_req_i[0]      = 1'b1;
            resp_data_bi[31:0] = 32'(i);
            #1 chk("fill_ack", 32'(resp_ack_o[0]), 32'(i <= 8));
            @(posedge clk_i); #1;
        end
        resp_req_i = '0;
        bus_read(addr_of(0, 'h00), rv);
        chk("fill_status", rv, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) begin
            bus_read(addr_of(0, 'h30), rv);
            chk("fill_pop", rv, 32'(i));
        end
        bus_read(addr_of(0, 'h00), rv);
        chk("drain_status", rv, 32'h0000_0004);
        bus_write(addr_of(0, 'h34), 32'h1, 4'hF);
        bus_read(addr_of(0, 'h00), rv);
        chk("clr_status", rv, 32'h0000_0000);

        // Empty pop, then simultaneous push and pop
        bus_read(addr_of(0, 'h30), rv);
        chk("empty_pop", rv, 32'd0);
        bus_read(addr_of(0, 'h00), rv);
        chk("empty_status", rv, 32'd0);
        resp_req_i[0]      = 1'b1;
        resp_data_bi[31:0] = 32'h55;
        @(posedge clk_i); #1;
        resp_req_i[0]      = 1'b0;
        resp_req_i[0]      = 1'b1;
        resp_data_bi[31:0] = 32'h77;
        bus_req_i          = 1'b1;
        bus_we_i           = 1'b0;
        bus_addr_bi        = addr_of(0, 'h30);
        @(posedge clk_i); #1;
        resp_req_i[0] = 1'b0;
        bus_req_i     = 1'b0;
        chk("sim_resp", 32'(bus_resp_o), 32'd1);
        chk("sim_old_head", bus_rdata_bo, 32'h55);
        @(posedge clk_i); #1;
        bus_read(addr_of(0, 'h00), rv);
        chk("sim_status", rv, 32'h0000_0102);
        bus_read(addr_of(0, 'h30), rv);
        chk("sim_new_head", rv, 32'h77);

        // Bus edges: unmapped reads and partial-byte write
        bus_read(addr_of(0, 'h3C), rv);
        chk("unmapped_off", rv, 32'd0);
        bus_read(addr_of(CH, 'h00), rv);
        chk("unmapped_ch", rv, 32'd0);
        bus_read(addr_of(0, 4 + 4*AN), rv);
        chk("unmapped_arg", rv, 32'd0);
        bus_write(addr_of(0, 'h04), 32'hDEAD_BEEF, 4'h3);
        chk("partial_wr_noresp", 32'(bus_resp_o), 32'd0);
        bus_read(addr_of(0, 'h04), rv);
        chk("partial_wr_arg0", rv, 32'hA5A5_0001);

        // Reset while pending
        bus_write(addr_of(0, 'h00), 32'h1, 4'hF);
        chk("pre_rst_req", 32'(cmd_req_o[0]), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("post_rst_req", 32'(cmd_req_o), 32'd0);
        end
        bus_read(addr_of(0, 'h00), rv);
        chk("post_rst_status0", rv, 32'd0);
        bus_read(addr_of(1, 'h00), rv);
        chk("post_rst_status1", rv, 32'd0);
        bus_read(addr_of(0, 'h04), rv);
        chk("post_rst_arg0", rv, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the bench always ends on its own
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/udm_cmd_bridge.md
UDM_CMD_BRIDGE -- requirements
Module: udm_cmd_bridge

Interface
REQ-001 SHALL have parameter CH_NUM, default 2: number of command channels, legal range 1..4.
REQ-002 SHALL have parameter ARG_NUM, default 4: number of 32-bit argument words per command, legal range 1..8.
REQ-003 SHALL have parameter RESP_DEPTH, default 8: depth of each per-channel response FIFO; power of 2, legal range 2..64.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h10000000: base address of the channel-0 window.
REQ-005 SHALL run on one clock, with an asynchronous, active-low reset.
REQ-006 SHALL provide the following ports:
- clk_i  in  1  clock
- arst_n_i  in  1  async active-low reset
- bus_req_i  in  1  bus request
- bus_we_i  in  1  1 = write
- bus_addr_bi  in  32  byte address
- bus_be_bi  in  4  byte enables
- bus_wdata_bi  in  32  write data
- bus_ack_o  out  1  request accepted
- bus_resp_o  out  1  read data valid
- bus_rdata_bo  out  32  read data
- cmd_req_o  out  CH_NUM  command valid, per channel
- cmd_data_bo  out  CH_NUM*ARG_NUM*32  command arguments; channel c, word k at bits [(c*ARG_NUM+k)*32 +: 32]
- cmd_ack_i  in  CH_NUM  command accepted, per channel
- resp_req_i  in  CH_NUM  response valid, per channel
- resp_data_bi  in  CH_NUM*32  response data, per channel
- resp_ack_o  out  CH_NUM  response accepted, per channel

Function
REQ-007 SHALL tie bus_ack_o = bus_req_i combinationally; every request is accepted in the cycle it is presented.
REQ-008 SHALL give each channel c a 0x40-byte window at BASE_ADDR + c*0x40, with these offsets:
- 0x00 CTRL/STATUS
- 0x04+4k ARGk
- 0x30 RESP_POP
- 0x34 CLR
REQ-009 SHALL honour writes only when bus_be_bi == 4'hF; all other writes are ignored.
REQ-010 SHALL answer every accepted read with bus_resp_o = 1 for exactly one cycle, one cycle after acceptance; bus_rdata_bo SHALL be 0 whenever bus_resp_o = 0.
REQ-011 SHALL return 0 for reads of unmapped addresses, including ARGk with k >= ARG_NUM; writes to unmapped addresses have no effect.
REQ-012 SHALL store a write to ARGk in that channel's staging register; the staging register is readable back.
REQ-013 SHALL implement a per-channel FSM with states IDLE and PEND.
- CTRL write with wdata[0] = 1 in IDLE: snapshot staging registers into cmd_data_bo, go to PEND.
- cmd_req_o SHALL be 1 exactly while in PEND, first asserted the cycle after the write.
REQ-014 SHALL, in PEND, hold cmd_data_bo stable until cmd_req_o & cmd_ack_i is sampled high; the FSM then returns to IDLE and cmd_req_o is 0 the next cycle.
REQ-015 SHALL treat a launch write while in PEND as rejected: the command is ignored, the sticky REJECT bit is set, and staging writes are still accepted.
REQ-016 SHALL return STATUS on a CTRL read as follows:
- bit0 BUSY (PEND)
- bit1 RESP_VALID (FIFO not empty)
- bit2 OVERFLOW (sticky)
- bit3 REJECT (sticky)
- bits[15:8] FIFO count
- all other bits 0
REQ-017 SHALL drive resp_ack_o[c] = !full[c]. When resp_req_i & resp_ack_o, resp_data_bi is pushed into the channel FIFO.
REQ-018 SHALL, when resp_req_i = 1 while the FIFO is full, drop the data and set OVERFLOW.
REQ-019 SHALL, on a RESP_POP read, return the FIFO head and pop it. A RESP_POP read on an empty FIFO SHALL return 0 with no state change.
REQ-020 SHALL, on a same-cycle push and pop, perform both and leave the count unchanged; the popped value is the old head.
REQ-021 SHALL, on a CLR write, clear the sticky bits selected by wdata[0] (OVERFLOW) and wdata[1] (REJECT). If a set event and a clear occur in the same cycle, set wins.
REQ-022 SHALL wrap FIFO pointers modulo RESP_DEPTH; the count is a $clog2(RESP_DEPTH)+1-bit field, zero-extended into STATUS.

Reset
REQ-023 SHALL, while arst_n_i = 0, asynchronously force:
- bus_resp_o = 0, bus_rdata_bo = 0
- cmd_req_o = 0, cmd_data_bo = 0
- staging registers = 0
- FSMs = IDLE
- FIFOs empty, sticky bits = 0
REQ-024 SHALL, if reset is asserted mid-PEND, abandon the pending command; no cmd_req_o is issued after release until a new launch.

Structure
REQ-025 SHALL take window offsets, STATUS bit positions and the window size 0x40 from package udm_bridge_pkg.
REQ-026 SHALL implement each response FIFO as one instance per channel of sub-module udm_bridge_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count.

Verification
REQ-027 Launch and hold: ch0 writes ARG0 = 32'hA5A5_0001, ARG1 = 32'h0000_0002, then CTRL = 1; hold cmd_ack_i[0] = 0 for 5 cycles -> cmd_req_o[0] = 1 with stable data for those 5 cycles, then drops the cycle after the ack.
REQ-028 Reject: launch ch1, then launch ch1 again before ack -> exactly one handshake occurs, and STATUS reads 32'h0000_0009 (BUSY + REJECT, count 0).
REQ-029 FIFO fill: push 9 responses 1..9 into ch0 with RESP_DEPTH = 8 -> resp_ack_o[0] = 0 on the 9th, STATUS = 32'h0000_0806, and eight RESP_POP reads return 1..8.
REQ-030 Empty pop and simultaneous push/pop: RESP_POP on an empty FIFO -> rdata 0 and count stays 0; with 1 entry present, push 32'h77 and pop in the same cycle -> count stays 1 and the old head is returned.
REQ-031 Bus edges: read an unmapped address, and write with be = 4'h3 to ARG0 -> both reads respond 0 one cycle after acceptance, and ARG0 is unchanged.
REQ-032 Reset mid-PEND: assert arst_n_i low for 2 cycles while in PEND -> cmd_req_o = 0 immediately and STATUS = 0 after release.
